// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet-tracking state used by the flit injector.
package noc_pkg;

  // Accept-side packet state: between packets, or inside a multi-beat packet.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

endpackage

// File: rtl/axis_flit_injector_if.sv
// AXI-Stream beat bundle feeding the flit injector.
interface axis_flit_injector_if #(
  parameter int TDATA_WIDTH = 32,
  parameter int TDEST_WIDTH = 4,
  parameter int TID_WIDTH   = 2
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TID_WIDTH-1:0]   tid;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/flit_skid_buffer.sv
// Two-entry FIFO holding tagged flits between AXIS acceptance and the router.
module flit_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_noc,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push_ok, pop_ok;
  logic [1:0][WIDTH-1:0] entry_q, entry_d;

  // Pointer and occupancy bookkeeping; push when full / pop when empty are ignored
  always_comb begin
    push_ok  = push && (count_q != 2'd2);
    pop_ok   = pop && (count_q != 2'd0);
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // Each slot loads only when the write pointer selects it
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    assign entry_d[gi] = (push_ok && (wr_ptr_q == 1'(gi))) ? push_data : entry_q[gi];
  end

  // Storage and pointer registers; reset empties the buffer
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      entry_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = entry_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/axis_flit_injector.sv
// Converts AXI-Stream packets into credit-flow-controlled NoC flits.
// Beats are tagged with the packet destination, buffered in a 2-entry skid
// FIFO and issued one per cycle while the router has buffer credits.
module axis_flit_injector
  import noc_pkg::*;
#(
  parameter int   TDATA_WIDTH       = 32,
  parameter int   TDEST_WIDTH       = 4,
  parameter int   TID_WIDTH         = 2,
  parameter int   FLIT_BUFFER_DEPTH = 8,
  localparam int  DEST_WIDTH        = TDEST_WIDTH + TID_WIDTH,
  localparam int  CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_n,
  axis_flit_injector_if.slave     axis_in,
  output logic [TDATA_WIDTH-1:0]  data_out,
  output logic [DEST_WIDTH-1:0]   dest_out,
  output logic                    is_tail_out,
  output logic                    send_out,
  input  logic                    credit_in,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    dest_err,
  output logic                    credit_err
);
  localparam int ENTRY_WIDTH = TDATA_WIDTH + DEST_WIDTH + 1;
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  logic                    ready_q, ready_d;
  pkt_state_e              state_q, state_d;
  logic [DEST_WIDTH-1:0]   dest_lat_q, dest_lat_d;
  logic                    dest_err_q, dest_err_d;
  logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
  logic                    credit_err_q, credit_err_d;
  logic                    send_q, send_d;
  logic [TDATA_WIDTH-1:0]  data_q, data_d;
  logic [DEST_WIDTH-1:0]   dest_q, dest_d;
  logic                    tail_q, tail_d;

  logic                    accept;
  logic [DEST_WIDTH-1:0]   beat_dest, tag_dest;
  logic [ENTRY_WIDTH-1:0]  in_entry, head_entry, send_entry;
  logic                    head_valid;
  logic [1:0]              fifo_count;
  logic                    fifo_push, fifo_pop, send;

  // tready depends only on registers; ready_q keeps it low until the first edge after reset
  assign axis_in.tready = ready_q && (fifo_count != 2'd2);
  assign accept         = axis_in.tvalid && axis_in.tready;
  assign beat_dest      = {axis_in.tid, axis_in.tdest};
  assign in_entry       = {axis_in.tdata, tag_dest, axis_in.tlast};
  assign ready_d        = 1'b1;

  // Packet tracking: first beat sets the destination, later beats inherit it
  always_comb begin
    state_d    = state_q;
    dest_lat_d = dest_lat_q;
    dest_err_d = dest_err_q;
    tag_dest   = beat_dest;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (!axis_in.tlast) begin
            state_d    = IN_PKT;
            dest_lat_d = beat_dest;
          end
        end
        IN_PKT: begin
          tag_dest = dest_lat_q;
          if (beat_dest != dest_lat_q) dest_err_d = 1'b1;
          if (axis_in.tlast) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Issue decision: an empty buffer lets an incoming beat bypass straight to the output
  always_comb begin
    send       = (credit_q != '0) && (head_valid || accept);
    fifo_pop   = send && head_valid;
    fifo_push  = accept && !(send && !head_valid);
    send_entry = head_valid ? head_entry : in_entry;
  end

  // Output flit register holds its last value between sends
  always_comb begin
    send_d = send;
    data_d = data_q;
    dest_d = dest_q;
    tail_d = tail_q;
    if (send) {data_d, dest_d, tail_d} = send_entry;
  end

  // Credit accounting with saturation at the router buffer depth
  always_comb begin
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    case ({send, credit_in})
      2'b10: credit_d = credit_q - CREDIT_WIDTH'(1);
      2'b01: begin
        if (credit_q >= CREDIT_MAX) credit_err_d = 1'b1;
        else                        credit_d     = credit_q + CREDIT_WIDTH'(1);
      end
      default: credit_d = credit_q;
    endcase
  end

  // State registers; reset drops any partial packet and restores full credit
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      state_q      <= IDLE;
      dest_lat_q   <= '0;
      dest_err_q   <= 1'b0;
      credit_q     <= CREDIT_MAX;
      credit_err_q <= 1'b0;
      send_q       <= 1'b0;
      data_q       <= '0;
      dest_q       <= '0;
      tail_q       <= 1'b0;
    end else begin
      ready_q      <= ready_d;
      state_q      <= state_d;
      dest_lat_q   <= dest_lat_d;
      dest_err_q   <= dest_err_d;
      credit_q     <= credit_d;
      credit_err_q <= credit_err_d;
      send_q       <= send_d;
      data_q       <= data_d;
      dest_q       <= dest_d;
      tail_q       <= tail_d;
    end
  end

  flit_skid_buffer #(
    .WIDTH (ENTRY_WIDTH)
  ) u_skid (
    .clk_noc    (clk_noc),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (in_entry),
    .pop        (fifo_pop),
    .head_valid (head_valid),
    .head_data  (head_entry),
    .count      (fifo_count)
  );

  assign data_out     = data_q;
  assign dest_out     = dest_q;
  assign is_tail_out  = tail_q;
  assign send_out     = send_q;
  assign credit_count = credit_q;
  assign dest_err     = dest_err_q;
  assign credit_err   = credit_err_q;

endmodule
